// File: rtl/servo_pwm_drv_pkg.sv
// rtl/servo_pwm_drv_pkg.sv - shared timing defaults and width clamp for the servo PWM driver
// Contents: default clock/frame/pulse constants and clamp_us(), which limits a width to [lo, hi].
package servo_pwm_drv_pkg;

  localparam int unsigned US_W           = 12;
  localparam int unsigned DEF_CLK_PER_US = 12;
  localparam int unsigned DEF_PERIOD_US  = 20000;
  localparam int unsigned DEF_MIN_US     = 500;
  localparam int unsigned DEF_MAX_US     = 2500;
  localparam int unsigned DEF_CENTER_US  = (DEF_MIN_US + DEF_MAX_US) / 2;

  function automatic logic [US_W-1:0] clamp_us(input logic [US_W-1:0] v,
                                               input logic [US_W-1:0] lo,
                                               input logic [US_W-1:0] hi);
    if (v < lo) return lo;
    else if (v > hi) return hi;
    else return v;
  endfunction

endpackage

// File: rtl/servo_pwm_drv_if.sv
// rtl/servo_pwm_drv_if.sv - command handshake bundle for the servo PWM driver
// Signals: cmd_valid/cmd_ready handshake, cmd_ch target channel, cmd_us requested width in us.
// master drives the command, slave (the driver) returns cmd_ready.
interface servo_pwm_drv_if #(
  parameter int unsigned CH_W = 2
);
  import servo_pwm_drv_pkg::*;

  logic            cmd_valid;
  logic            cmd_ready;
  logic [CH_W-1:0] cmd_ch;
  logic [US_W-1:0] cmd_us;

  modport master (output cmd_valid, output cmd_ch, output cmd_us, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_ch, input cmd_us, output cmd_ready);

endinterface

// File: rtl/servo_pwm_drv_servo_ch.sv
// rtl/servo_pwm_drv_servo_ch.sv - one servo channel: pending/active width, clamp and output compare
// Ports: clk, rst_n (async, active-low); boundary_i frame boundary strobe; enable_i latched enable;
// load_i accept a command for this channel; cmd_us_i raw width; us_cnt_i frame position;
// pend_o pending width not yet applied; pwm_o registered pulse output.
module servo_ch
  import servo_pwm_drv_pkg::*;
#(
  parameter int unsigned CNT_W    = 15,
  parameter int unsigned MIN_US   = DEF_MIN_US,
  parameter int unsigned MAX_US   = DEF_MAX_US,
  parameter int unsigned RESET_US = DEF_CENTER_US
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             boundary_i,
  input  logic             enable_i,
  input  logic             load_i,
  input  logic [US_W-1:0]  cmd_us_i,
  input  logic [CNT_W-1:0] us_cnt_i,
  output logic             pend_o,
  output logic             pwm_o
);

  logic [US_W-1:0] pend_q, pend_d, act_q, act_d;
  logic            flag_q, flag_d, pwm_q, pwm_d;

  always_comb begin
    pend_d = pend_q;
    act_d  = act_q;
    flag_d = flag_q;
    // Apply uses the flag as it stood before this edge, so a load on the
    // boundary cycle waits for the following boundary.
    if (boundary_i && flag_q) begin
      act_d  = pend_q;
      flag_d = 1'b0;
    end
    if (load_i) begin
      pend_d = clamp_us(cmd_us_i, US_W'(MIN_US), US_W'(MAX_US));
      flag_d = 1'b1;
    end
    pwm_d = enable_i && (32'(us_cnt_i) < 32'(act_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      act_q  <= US_W'(RESET_US);
      flag_q <= 1'b0;
      pwm_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      act_q  <= act_d;
      flag_q <= flag_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pend_o = flag_q;
  assign pwm_o  = pwm_q;

endmodule

// File: rtl/servo_pwm_drv.sv
// rtl/servo_pwm_drv.sv - multi-channel servo PWM driver with frame-synchronous width updates
// Ports: clk; rst_n (async, active-low); en global enable, sampled at frame boundaries;
// cmd command handshake (slave); servo_pwm registered pulses; frame_sync first clk of each frame.
module servo_pwm_drv
  import servo_pwm_drv_pkg::*;
#(
  parameter int unsigned CLK_PER_US = DEF_CLK_PER_US,
  parameter int unsigned PERIOD_US  = DEF_PERIOD_US,
  parameter int unsigned MIN_US     = DEF_MIN_US,
  parameter int unsigned MAX_US     = DEF_MAX_US,
  parameter int unsigned CH_NUM     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  servo_pwm_drv_if.slave    cmd,
  output logic [CH_NUM-1:0] servo_pwm,
  output logic              frame_sync
);

  localparam int unsigned PRE_W     = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int unsigned CNT_W     = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
  localparam int unsigned CH_W      = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int unsigned CENTER_US = (MIN_US + MAX_US) / 2;

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [CNT_W-1:0]  us_cnt_q, us_cnt_d;
  logic              fs_q, en_q, en_d, rdy_q;
  logic              us_tick, boundary, sel_pend, accept;
  logic [CH_NUM-1:0] pend_flag, load;

  assign us_tick  = (pre_q == PRE_W'(CLK_PER_US - 1));
  // Boundary is the cycle whose edge wraps us_cnt back to 0.
  assign boundary = us_tick && (us_cnt_q == CNT_W'(PERIOD_US - 1));

  always_comb begin
    pre_d    = us_tick ? '0 : pre_q + 1'b1;
    us_cnt_d = us_cnt_q;
    if (us_tick) us_cnt_d = boundary ? '0 : us_cnt_q + 1'b1;
    en_d     = boundary ? en : en_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q    <= '0;
      us_cnt_q <= '0;
      fs_q     <= 1'b0;
      en_q     <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      us_cnt_q <= us_cnt_d;
      fs_q     <= boundary;
      en_q     <= en_d;
      rdy_q    <= 1'b1;
    end
  end

  // Channel decode by compare so an out-of-range cmd_ch matches nothing:
  // it sees no pending flag (ready) and loads no channel (discarded).
  always_comb begin
    sel_pend = 1'b0;
    load     = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (cmd.cmd_ch == CH_W'(i)) begin
        sel_pend = pend_flag[i];
        load[i]  = accept;
      end
    end
  end

  assign cmd.cmd_ready = rdy_q && !sel_pend;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign frame_sync    = fs_q;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    servo_ch #(
      .CNT_W    (CNT_W),
      .MIN_US   (MIN_US),
      .MAX_US   (MAX_US),
      .RESET_US (CENTER_US)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .boundary_i (boundary),
      .enable_i   (en_q),
      .load_i     (load[g]),
      .cmd_us_i   (cmd.cmd_us),
      .us_cnt_i   (us_cnt_q),
      .pend_o     (pend_flag[g]),
      .pwm_o      (servo_pwm[g])
    );
  end

endmodule

// File: tb/tb_servo_pwm_drv.sv
// tb/tb_servo_pwm_drv.sv - directed self-checking bench for servo_pwm_drv (scaled-down timing)
module tb_servo_pwm_drv;

  localparam int CPU   = 2;
  localparam int PER   = 60;
  localparam int MINU  = 5;
  localparam int MAXU  = 25;
  localparam int CHN   = 3;
  localparam int FRAME = CPU * PER;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic [CHN-1:0] servo_pwm;
  logic           frame_sync;

  servo_pwm_drv_if #(.CH_W(2)) cmd_if ();

  servo_pwm_drv #(
    .CLK_PER_US (CPU),
    .PERIOD_US  (PER),
    .MIN_US     (MINU),
    .MAX_US     (MAXU),
    .CH_NUM     (CHN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .cmd        (cmd_if),
    .servo_pwm  (servo_pwm),
    .frame_sync (frame_sync)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [23:0] w_got;
  logic [5:0]  r_got;
  int          fs_cnt;

  // Observe one frame starting at the current negedge (frame_sync cycle).
  task automatic measure();
    int hi [CHN];
    int rs [CHN];
    logic [CHN-1:0] prev, cur;
    for (int c = 0; c < CHN; c++) begin
      hi[c] = 0;
      rs[c] = 0;
    end
    fs_cnt = 0;
    prev = servo_pwm;
    for (int k = 0; k < FRAME; k++) begin
      cur = servo_pwm;
      for (int c = 0; c < CHN; c++) begin
        if (cur[c]) hi[c]++;
        if (cur[c] && !prev[c]) rs[c]++;
      end
      if (frame_sync) fs_cnt++;
      prev = cur;
      @(negedge clk);
    end
    w_got = {hi[2][7:0], hi[1][7:0], hi[0][7:0]};
    r_got = {rs[2][1:0], rs[1][1:0], rs[0][1:0]};
  endtask

  task automatic send_cmd(input int ch, input int us);
    int n = 0;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_ch    = ch[1:0];
    cmd_if.cmd_us    = us[11:0];
    #1;
    while (cmd_if.cmd_ready !== 1'b1 && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_if.cmd_ready !== 1'b1) begin
      $display("FAIL send_cmd_timeout ch%0d got ready=%b want 1", ch, cmd_if.cmd_ready);
      errors++;
    end
    @(posedge clk);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    int n, hi;
    rst_n = 1'b0; en = 1'b1;
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_ch = '0; cmd_if.cmd_us = '0;
    repeat (3) @(negedge clk);
    checks++; if (servo_pwm !== 3'b000) begin $display("FAIL reset_pwm got %b want 000", servo_pwm); errors++; end
    checks++; if (frame_sync !== 1'b0) begin $display("FAIL reset_fs got %b want 0", frame_sync); errors++; end
    checks++; if (cmd_if.cmd_ready !== 1'b0) begin $display("FAIL reset_ready got %b want 0", cmd_if.cmd_ready); errors++; end
    rst_n = 1'b1;
    #1;
    checks++; if (cmd_if.cmd_ready !== 1'b0) begin $display("FAIL ready_before_edge got %b want 0", cmd_if.cmd_ready); errors++; end
    @(negedge clk);
    checks++; if (cmd_if.cmd_ready !== 1'b1) begin $display("FAIL ready_after_edge got %b want 1", cmd_if.cmd_ready); errors++; end
    n = 1; hi = 0;
    while (frame_sync !== 1'b1 && n < 2 * FRAME) begin
      if (|servo_pwm) hi++;
      @(negedge clk);
      n++;
    end
    checks++; if (n !== FRAME) begin $display("FAIL first_frame_len got %0d want %0d", n, FRAME); errors++; end
    checks++; if (hi !== 0) begin $display("FAIL first_frame_low got %0d want 0", hi); errors++; end
  endtask

  task automatic test_default();
    measure();
    checks++; if (w_got !== {8'd30, 8'd30, 8'd30}) begin $display("FAIL default_width got %0d/%0d/%0d want 30/30/30", w_got[7:0], w_got[15:8], w_got[23:16]); errors++; end
    checks++; if (r_got !== 6'b010101) begin $display("FAIL default_rises got %b want 010101", r_got); errors++; end
    checks++; if (fs_cnt !== 1) begin $display("FAIL default_fs_count got %0d want 1", fs_cnt); errors++; end
    checks++; if (frame_sync !== 1'b1) begin $display("FAIL default_fs_period got %b want 1", frame_sync); errors++; end
  endtask

  task automatic test_mid_cmd();
    fork
      measure();
      begin repeat (40) @(negedge clk); send_cmd(0, 10); end
    join
    checks++; if (w_got !== {8'd30, 8'd30, 8'd30}) begin $display("FAIL mid_cmd_cur got %0d/%0d/%0d want 30/30/30", w_got[7:0], w_got[15:8], w_got[23:16]); errors++; end
    measure();
    checks++; if (w_got !== {8'd30, 8'd30, 8'd20}) begin $display("FAIL mid_cmd_next got %0d/%0d/%0d want 20/30/30", w_got[7:0], w_got[15:8], w_got[23:16]); errors++; end
  endtask

  task automatic test_clamp();
    fork
      measure();
      begin repeat (40) @(negedge clk); send_cmd(1, 1); end
    join
    checks++; if (w_got !== {8'd30, 8'd30, 8'd20}) begin $display("FAIL clamp_f1 got %0d/%0d/%0d want 20/30/30", w_got[7:0], w_got[15:8], w_got[23:16]); errors++; end
    fork
      measure();
      begin repeat (40) @(negedge clk); send_cmd(1, 100); end
    join
    checks++; if (w_got !== {8'd30, 8'd10, 8'd20}) begin $display("FAIL clamp_low got %0d/%0d/%0d want 20/10/30", w_got[7:0], w_got[15:8], w_got[23:16]); errors++; end
    measure();
    checks++; if (w_got !== {8'd30, 8'd50, 8'd20}) begin $display("FAIL clamp_high got %0d/%0d/%0d want 20/50/30", w_got[7:0], w_got[15:8], w_got[23:16]); errors++; end
  endtask

  task automatic test_back_to_back();
    fork
      measure();
      begin
        int n = 0;
        repeat (20) @(negedge clk);
        send_cmd(2, 8);
        repeat (19) @(negedge clk);
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_ch = 2'd2; cmd_if.cmd_us = 12'd12;
        #1;
        checks++; if (cmd_if.cmd_ready !== 1'b0) begin $display("FAIL b2b_blocked got %b want 0", cmd_if.cmd_ready); errors++; end
        while (cmd_if.cmd_ready !== 1'b1 && n < 2 * FRAME) begin
          @(negedge clk);
          n++;
        end
        checks++; if (n !== FRAME - 40) begin $display("FAIL b2b_ready_delay got %0d want %0d", n, FRAME - 40); errors++; end
        checks++; if (frame_sync !== 1'b1) begin $display("FAIL b2b_ready_at_sync got %b want 1", frame_sync); errors++; end
      end
    join
    checks++; if (w_got !== {8'd30, 8'd50, 8'd20}) begin $display("FAIL b2b_f1 got %0d/%0d/%0d want 20/50/30", w_got[7:0], w_got[15:8], w_got[23:16]); errors++; end
    fork
      measure();
      begin @(posedge clk); #1; cmd_if.cmd_valid = 1'b0; end
    join
    checks++; if (w_got !== {8'd16, 8'd50, 8'd20}) begin $display("FAIL b2b_first got %0d/%0d/%0d want 20/50/16", w_got[7:0], w_got[15:8], w_got[23:16]); errors++; end
    measure();
    checks++; if (w_got !== {8'd24, 8'd50, 8'd20}) begin $display("FAIL b2b_second got %0d/%0d/%0d want 20/50/24", w_got[7:0], w_got[15:8], w_got[23:16]); errors++; end
  endtask

  task automatic test_boundary();
    fork
      measure();
      begin
        repeat (10) @(negedge clk);
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_ch = 2'd3; cmd_if.cmd_us = 12'd7;
        #1;
        checks++; if (cmd_if.cmd_ready !== 1'b1) begin $display("FAIL oor_ready got %b want 1", cmd_if.cmd_ready); errors++; end
        @(posedge clk);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        repeat (FRAME - 12) @(negedge clk);
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_ch = 2'd0; cmd_if.cmd_us = 12'd15;
        #1;
        checks++; if (cmd_if.cmd_ready !== 1'b1) begin $display("FAIL bnd_ready got %b want 1", cmd_if.cmd_ready); errors++; end
        @(posedge clk);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
      end
    join
    checks++; if (w_got !== {8'd24, 8'd50, 8'd20}) begin $display("FAIL bnd_f1 got %0d/%0d/%0d want 20/50/24", w_got[7:0], w_got[15:8], w_got[23:16]); errors++; end
    measure();
    checks++; if (w_got !== {8'd24, 8'd50, 8'd20}) begin $display("FAIL bnd_not_yet got %0d/%0d/%0d want 20/50/24", w_got[7:0], w_got[15:8], w_got[23:16]); errors++; end
    measure();
    checks++; if (w_got !== {8'd24, 8'd50, 8'd30}) begin $display("FAIL bnd_applied got %0d/%0d/%0d want 30/50/24", w_got[7:0], w_got[15:8], w_got[23:16]); errors++; end
  endtask

  task automatic test_enable();
    fork
      measure();
      begin repeat (10) @(negedge clk); en = 1'b0; end
    join
    checks++; if (w_got !== {8'd24, 8'd50, 8'd30}) begin $display("FAIL en_drop_full got %0d/%0d/%0d want 30/50/24", w_got[7:0], w_got[15:8], w_got[23:16]); errors++; end
    checks++; if (r_got !== 6'b010101) begin $display("FAIL en_drop_rises got %b want 010101", r_got); errors++; end
    fork
      measure();
      begin repeat (10) @(negedge clk); en = 1'b1; end
    join
    checks++; if (w_got !== 24'd0) begin $display("FAIL en_off_frame got %0d/%0d/%0d want 0/0/0", w_got[7:0], w_got[15:8], w_got[23:16]); errors++; end
    measure();
    checks++; if (w_got !== {8'd24, 8'd50, 8'd30}) begin $display("FAIL en_back got %0d/%0d/%0d want 30/50/24", w_got[7:0], w_got[15:8], w_got[23:16]); errors++; end
  endtask

  task automatic test_async_reset();
    int n, hi;
    repeat (10) @(negedge clk);
    checks++; if (servo_pwm !== 3'b111) begin $display("FAIL pre_reset_pwm got %b want 111", servo_pwm); errors++; end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (servo_pwm !== 3'b000) begin $display("FAIL async_reset_pwm got %b want 000", servo_pwm); errors++; end
    @(negedge clk);
    checks++; if (cmd_if.cmd_ready !== 1'b0) begin $display("FAIL async_reset_ready got %b want 0", cmd_if.cmd_ready); errors++; end
    rst_n = 1'b1;
    @(negedge clk);
    n = 1; hi = 0;
    while (frame_sync !== 1'b1 && n < 2 * FRAME) begin
      if (|servo_pwm) hi++;
      @(negedge clk);
      n++;
    end
    checks++; if (n !== FRAME) begin $display("FAIL rst_first_len got %0d want %0d", n, FRAME); errors++; end
    checks++; if (hi !== 0) begin $display("FAIL rst_first_low got %0d want 0", hi); errors++; end
    measure();
    checks++; if (w_got !== {8'd30, 8'd30, 8'd30}) begin $display("FAIL rst_center got %0d/%0d/%0d want 30/30/30", w_got[7:0], w_got[15:8], w_got[23:16]); errors++; end
  endtask

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_default();
    test_mid_cmd();
    test_clamp();
    test_back_to_back();
    test_boundary();
    test_enable();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/servo_pwm_drv.md
SERVO_PWM_DRV -- requirements
Module: servo_pwm_drv

Interface
REQ-001 Parameter CLK_PER_US, default 12, SHALL set the clk cycles per 1 us tick (12 MHz clk).
REQ-002 Parameter PERIOD_US, default 20000, SHALL set the frame length in us.
REQ-003 Parameter MIN_US, default 500, SHALL set the minimum pulse width in us.
REQ-004 Parameter MAX_US, default 2500, SHALL set the maximum pulse width in us.
REQ-005 Parameter CH_NUM, default 4, SHALL set the number of servo channels.
REQ-006 Port clk, input, 1 bit: single clock; all logic SHALL be synchronous to its rising edge.
REQ-007 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 Port en, input, 1 bit: global output enable.
REQ-009 Port cmd_valid, input, 1 bit: a command is offered.
REQ-010 Port cmd_ready, output, 1 bit: the block accepts the offered command.
REQ-011 Port cmd_ch, input, clog2(CH_NUM) bits: target channel.
REQ-012 Port cmd_us, input, 12 bits: requested pulse width in us.
REQ-013 Port servo_pwm, output, CH_NUM bits: registered pulse outputs to the servo pins.
REQ-014 Port frame_sync, output, 1 bit: one-cycle pulse on the first clk of each frame.

Function
REQ-015 A prescaler SHALL count 0..CLK_PER_US-1 and assert a one-cycle us_tick when it wraps.
REQ-016 A frame counter us_cnt SHALL advance on us_tick over 0..PERIOD_US-1 and wrap to 0.
REQ-017 The frame boundary SHALL be the cycle where us_cnt wraps to 0; frame_sync SHALL pulse on the following cycle.
REQ-018 A command SHALL be accepted on a cycle with cmd_valid=1 and cmd_ready=1.
REQ-019 cmd_ready SHALL be 1 unless the channel addressed by cmd_ch already holds an unapplied pending width.
REQ-020 cmd_ready SHALL be 1 for a cmd_ch >= CH_NUM; such a command SHALL be accepted and discarded.
REQ-021 An accepted cmd_us SHALL be clamped to [MIN_US, MAX_US] and stored in that channel's pending register, with its pending flag set.
REQ-022 At each frame boundary, every channel with its pending flag set SHALL copy pending into active and clear the flag.
REQ-023 A command accepted on the frame-boundary cycle SHALL NOT be applied in the frame starting there; it SHALL apply at the next boundary.
REQ-024 servo_pwm[i] SHALL be 1 while us_cnt < active[i] and the latched enable is 1, and 0 otherwise.
REQ-025 Each servo_pwm[i] SHALL be registered, giving one clk of latency from us_cnt to the pin.
REQ-026 Pulse widths SHALL be exact: active[i]*CLK_PER_US clk cycles high per frame, with no glitches within a frame.
REQ-027 en SHALL be sampled only at frame boundaries; a change SHALL take effect from the next frame, never truncating a pulse.
REQ-028 All width arithmetic SHALL be unsigned; us_cnt SHALL be sized as clog2(PERIOD_US) bits.

Reset
REQ-029 While rst_n=0: servo_pwm=0, frame_sync=0, cmd_ready=0, counters=0, pending flags cleared, active[i]=(MIN_US+MAX_US)/2 (1500), latched enable=0.
REQ-030 Assertion of rst_n mid-frame SHALL force servo_pwm low asynchronously.
REQ-031 After release, the first frame SHALL start with us_cnt=0, and cmd_ready SHALL rise on the first clk edge after release.

Structure
REQ-032 A shared package SHALL hold the default timing constants (CLK_PER_US, PERIOD_US, MIN_US, MAX_US, CENTER_US) and the clamp function.
REQ-033 One sub-module, servo_ch, SHALL hold one channel's pending/active registers, clamp logic and output compare; it SHALL be instantiated CH_NUM times.

Verification
REQ-034 Reset, en=1, no command -> every channel high for 18000 clk (1500 us) per 240000-clk frame; frame_sync every 240000 clk.
REQ-035 cmd ch0=1000 mid-frame -> the current frame is unchanged; from the next frame ch0 is high for 12000 clk; other channels are unchanged.
REQ-036 cmd ch1=100, then (next frame) ch1=4000 -> ch1 high for 6000 clk, then 30000 clk (clamped).
REQ-037 Two commands to ch2 within one frame -> cmd_ready=0 for the second until the boundary; the second is accepted after the boundary and applied one frame later.
REQ-038 Command accepted exactly on the boundary cycle -> applied one frame later; en dropped mid-pulse -> the pulse completes and the next frame is all-low.
REQ-039 rst_n asserted mid-pulse -> servo_pwm=0 without waiting for clk; after release, widths return to 1500 us.
